// File: rtl/rx_fifo_crc_framer.sv
// rx_fifo_crc_framer: takes words from a four-phase tsent/trecieve handshake,
// folds each word into a running CRC BPC bits per clock, and pushes it to a
// FIFO write port with fifo_busy back-pressure. In frame mode the frame CRC
// is appended as an extra FIFO word every FRAME_LEN data words. A stalled
// push is abandoned after TIMEOUT busy cycles and flagged in a sticky error.
module rx_fifo_crc_framer #(
  parameter int                 DATA_W    = 8,
  parameter int                 BPC       = 1,
  parameter int                 CRC_W     = 8,
  parameter logic [CRC_W-1:0]   CRC_POLY  = CRC_W'(7),
  parameter logic [CRC_W-1:0]   CRC_INIT  = '0,
  parameter int                 FRAME_LEN = 4,
  parameter int                 TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              append_crc,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tsent,
  output logic              trecieve,
  input  logic              fifo_busy,
  output logic              fifo_we,
  output logic [DATA_W-1:0] fifo_data,
  output logic [CRC_W-1:0]  crc,
  output logic              idle,
  output logic              frame_done,
  output logic [3:0]        error,
  input  logic              clr_err
);

  localparam int BEATS  = DATA_W / BPC;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int WCNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {
    WAIT_REQ, SHIFT, PUSH, ACK, REL, CRC_PUSH, CRC_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                fmode_q, fmode_d;
  logic [CRC_W-1:0]    crc_run_q, crc_run_d;
  logic [CRC_W-1:0]    crc_d;
  logic                trecieve_d, fifo_we_d, idle_d, frame_done_d;
  logic [DATA_W-1:0]   fifo_data_d;
  logic [1:0]          err_q, err_d, err_set;
  logic [DATA_W-1:0]   sreg_q, sreg_d, word_q, word_d;

  // Fold BPC bits (MSB first) into the CRC, non-reflected, no final XOR.
  function automatic logic [CRC_W-1:0] crc_fold(input logic [CRC_W-1:0] c,
                                                input logic [BPC-1:0]   bits);
    logic [CRC_W-1:0] r;
    r = c;
    for (int i = BPC - 1; i >= 0; i--) begin
      if (r[CRC_W-1] ^ bits[i]) r = (r << 1) ^ CRC_POLY;
      else                      r = r << 1;
    end
    return r;
  endfunction

  assign error = {2'b00, err_q};

  // Next-state and next-output logic for the handshake/push sequencer.
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    tcnt_d       = tcnt_q;
    wcnt_d       = wcnt_q;
    fmode_d      = fmode_q;
    crc_run_d    = crc_run_q;
    crc_d        = crc;
    trecieve_d   = trecieve;
    fifo_we_d    = fifo_we;
    fifo_data_d  = fifo_data;
    frame_done_d = 1'b0;
    err_set      = 2'b00;
    sreg_d       = sreg_q;
    word_d       = word_q;
    case (state_q)
      WAIT_REQ: begin
        if (tsent) begin
          word_d  = rx_data;
          sreg_d  = rx_data;
          fmode_d = append_crc;
          bcnt_d  = BCNT_W'(BEATS - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        crc_run_d = crc_fold(crc_run_q, sreg_q[DATA_W-1 -: BPC]);
        sreg_d    = sreg_q << BPC;
        if (bcnt_q == '0) state_d = PUSH;
        else              bcnt_d  = bcnt_q - 1'b1;
      end
      PUSH: begin
        if (!fifo_busy) begin
          fifo_data_d = word_q;
          fifo_we_d   = 1'b1;
          state_d     = ACK;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          // Word is dropped but its CRC contribution and count are kept.
          err_set[0] = 1'b1;
          state_d    = ACK;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ACK: begin
        fifo_we_d  = 1'b0;
        trecieve_d = 1'b1;
        wcnt_d     = wcnt_q + 1'b1;
        tcnt_d     = '0;
        if (!fmode_q) crc_d = crc_run_q;
        state_d    = REL;
      end
      REL: begin
        if (!tsent) begin
          trecieve_d = 1'b0;
          if (fmode_q && wcnt_q == WCNT_W'(FRAME_LEN)) begin
            state_d = CRC_PUSH;
          end else begin
            if (wcnt_q == WCNT_W'(FRAME_LEN)) wcnt_d = '0;
            state_d = WAIT_REQ;
          end
        end
      end
      CRC_PUSH: begin
        if (!fifo_busy) begin
          fifo_data_d              = '0;
          fifo_data_d[CRC_W-1:0]   = crc_run_q;
          fifo_we_d                = 1'b1;
          state_d                  = CRC_DONE;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          err_set[1] = 1'b1;
          state_d    = CRC_DONE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      CRC_DONE: begin
        fifo_we_d    = 1'b0;
        frame_done_d = 1'b1;
        crc_d        = crc_run_q;
        crc_run_d    = CRC_INIT;
        wcnt_d       = '0;
        tcnt_d       = '0;
        state_d      = WAIT_REQ;
      end
      default: state_d = WAIT_REQ;
    endcase
    err_d  = clr_err ? 2'b00 : (err_q | err_set);
    idle_d = (state_d == WAIT_REQ);
  end

  // Control and output registers; enable low freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WAIT_REQ;
      bcnt_q     <= '0;
      tcnt_q     <= '0;
      wcnt_q     <= '0;
      fmode_q    <= 1'b0;
      crc_run_q  <= CRC_INIT;
      crc        <= CRC_INIT;
      trecieve   <= 1'b0;
      fifo_we    <= 1'b0;
      fifo_data  <= '0;
      idle       <= 1'b1;
      frame_done <= 1'b0;
      err_q      <= 2'b00;
    end else if (enable) begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      tcnt_q     <= tcnt_d;
      wcnt_q     <= wcnt_d;
      fmode_q    <= fmode_d;
      crc_run_q  <= crc_run_d;
      crc        <= crc_d;
      trecieve   <= trecieve_d;
      fifo_we    <= fifo_we_d;
      fifo_data  <= fifo_data_d;
      idle       <= idle_d;
      frame_done <= frame_done_d;
      err_q      <= err_d;
    end
  end

  // Word latch and CRC shift register; contents only matter after a request.
  always_ff @(posedge clk) begin
    if (enable) begin
      sreg_q <= sreg_d;
      word_q <= word_d;
    end
  end

endmodule

// File: tb/tb_rx_fifo_crc_framer.sv
// Directed bench for rx_fifo_crc_framer: an 8-bit/BPC=1 instance (FRAME_LEN=9,
// TIMEOUT=4) and a 16-bit/BPC=4 instance, checked against hand-computed values.
module tb_rx_fifo_crc_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, clr_err;

  logic        append8, tsent8, trec8, busy8, we8, idle8, fd8;
  logic [7:0]  rx8, fdata8, crc8;
  logic [3:0]  err8;

  logic        append16, tsent16, trec16, busy16, we16, idle16, fd16;
  logic [15:0] rx16, fdata16;
  logic [7:0]  crc16;
  logic [3:0]  err16;

  int err_cnt = 0;
  int chk_cnt = 0;

  rx_fifo_crc_framer #(
    .DATA_W(8), .BPC(1), .CRC_W(8), .CRC_POLY(8'h07), .CRC_INIT(8'h00),
    .FRAME_LEN(9), .TIMEOUT(4)
  ) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable), .append_crc(append8),
    .rx_data(rx8), .tsent(tsent8), .trecieve(trec8), .fifo_busy(busy8),
    .fifo_we(we8), .fifo_data(fdata8), .crc(crc8), .idle(idle8),
    .frame_done(fd8), .error(err8), .clr_err(clr_err)
  );

  rx_fifo_crc_framer #(
    .DATA_W(16), .BPC(4), .CRC_W(8), .CRC_POLY(8'h07), .CRC_INIT(8'h00),
    .FRAME_LEN(9), .TIMEOUT(255)
  ) u_dut16 (
    .clk(clk), .reset(reset), .enable(enable), .append_crc(append16),
    .rx_data(rx16), .tsent(tsent16), .trecieve(trec16), .fifo_busy(busy16),
    .fifo_we(we16), .fifo_data(fdata16), .crc(crc16), .idle(idle16),
    .frame_done(fd16), .error(err16), .clr_err(clr_err)
  );

  // Write / frame_done monitor for the 8-bit instance
  int         we_tot8 = 0;
  int         fd_tot8 = 0;
  logic [7:0] last_w8 = 8'h00;
  always @(negedge clk) begin
    if (we8) begin
      we_tot8 <= we_tot8 + 1;
      last_w8 <= fdata8;
    end
    if (fd8) fd_tot8 <= fd_tot8 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Present one word; return edges from the sampling edge to the first write,
  // number of write cycles seen, written data, and whether trecieve arrived.
  task automatic send8(input logic [7:0] d, input int busy_n, output int lat,
                       output int wecyc, output logic [7:0] dout, output bit acked);
    lat = -1; wecyc = 0; dout = 8'h00; acked = 1'b0;
    @(negedge clk);
    rx8 = d; tsent8 = 1'b1; busy8 = (busy_n > 0);
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n >= 8 + busy_n) busy8 = 1'b0;
      if (we8) begin
        wecyc++;
        if (lat < 0) begin lat = n; dout = fdata8; end
      end
      if (trec8) begin acked = 1'b1; break; end
    end
    busy8 = 1'b0;
  endtask

  task automatic release8(output int edges);
    edges = -1;
    tsent8 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (!trec8) begin edges = n; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int         lat, wecyc, rel, w0, f0;
  logic [7:0] dout;
  logic [15:0] d16;
  bit         acked;

  initial begin
    reset = 1'b0; enable = 1'b1; clr_err = 1'b0;
    append8 = 1'b0; tsent8 = 1'b0; busy8 = 1'b0; rx8 = 8'h00;
    append16 = 1'b0; tsent16 = 1'b0; busy16 = 1'b0; rx16 = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_trecieve", trec8, 1'b0);
    check("rst_fifo_we", we8, 1'b0);
    check("rst_fifo_data", fdata8, 8'h00);
    check("rst_crc", crc8, 8'h00);
    check("rst_idle", idle8, 1'b1);
    check("rst_frame_done", fd8, 1'b0);
    check("rst_error", err8, 4'h0);
    reset = 1'b1;

    // Single word, non-frame mode
    send8(8'h01, 0, lat, wecyc, dout, acked);
    check("t1_latency", lat, 9);
    check("t1_we_cycles", wecyc, 1);
    check("t1_data", dout, 8'h01);
    check("t1_acked", acked, 1'b1);
    release8(rel);
    check("t1_release_edges", rel, 1);
    check("t1_crc", crc8, 8'h07);
    check("t1_idle", idle8, 1'b1);

    // Two bytes through BPC=1 vs one 16-bit word through BPC=4
    apply_reset();
    send8(8'h31, 0, lat, wecyc, dout, acked); release8(rel);
    send8(8'h32, 0, lat, wecyc, dout, acked); release8(rel);
    check("t3_crc_bpc1", crc8, 8'h72);

    @(negedge clk);
    rx16 = 16'h3132; tsent16 = 1'b1;
    @(posedge clk);
    lat = -1; d16 = 16'h0000; acked = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (we16 && lat < 0) begin lat = n; d16 = fdata16; end
      if (trec16) begin acked = 1'b1; break; end
    end
    check("t3_latency", lat, 5);
    check("t3_data", d16, 16'h3132);
    check("t3_acked", acked, 1'b1);
    check("t3_crc_bpc4", crc16, 8'h72);
    tsent16 = 1'b0;
    rel = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (!trec16) begin rel = n; break; end
    end
    check("t3_release_edges", rel, 1);
    check("t3_idle", idle16, 1'b1);
    check("t3_error", err16, 4'h0);
    check("t3_frame_done", fd16, 1'b0);

    // Busy for 3 cycles, then released
    apply_reset();
    send8(8'h5A, 3, lat, wecyc, dout, acked);
    check("t4_latency", lat, 12);
    check("t4_we_cycles", wecyc, 1);
    check("t4_data", dout, 8'h5A);
    check("t4_error", err8, 4'h0);
    release8(rel);

    // Busy held: timeout drops the word but still acks and updates CRC
    apply_reset();
    send8(8'h01, 100, lat, wecyc, dout, acked);
    check("t5_we_cycles", wecyc, 0);
    check("t5_acked", acked, 1'b1);
    check("t5_error", err8, 4'h1);
    release8(rel);
    check("t5_crc", crc8, 8'h07);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    check("t5_error_cleared", err8, 4'h0);

    // Frame mode, "123456789", two frames
    apply_reset();
    append8 = 1'b1;
    for (int r = 0; r < 2; r++) begin
      w0 = we_tot8; f0 = fd_tot8;
      for (int i = 0; i < 9; i++) begin
        send8(8'h31 + 8'(i), 0, lat, wecyc, dout, acked);
        release8(rel);
      end
      repeat (6) @(posedge clk); #1;
      check("t2_writes", we_tot8 - w0, 10);
      check("t2_crc_word", last_w8, 8'hF4);
      check("t2_frame_done", fd_tot8 - f0, 1);
      check("t2_crc", crc8, 8'hF4);
    end
    append8 = 1'b0;

    // Asynchronous reset during SHIFT
    @(negedge clk);
    rx8 = 8'hAA; tsent8 = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6s_idle", idle8, 1'b1);
    check("t6s_trecieve", trec8, 1'b0);
    check("t6s_fifo_we", we8, 1'b0);
    check("t6s_fifo_data", fdata8, 8'h00);
    check("t6s_crc", crc8, 8'h00);
    tsent8 = 1'b0;
    @(negedge clk); reset = 1'b1;
    send8(8'h01, 0, lat, wecyc, dout, acked);
    check("t6s_latency", lat, 9);
    release8(rel);
    check("t6s_crc_after", crc8, 8'h07);

    // Asynchronous reset during REL
    send8(8'h55, 0, lat, wecyc, dout, acked);
    #2 reset = 1'b0;
    #1;
    check("t6r_trecieve", trec8, 1'b0);
    check("t6r_idle", idle8, 1'b1);
    check("t6r_crc", crc8, 8'h00);
    tsent8 = 1'b0;
    @(negedge clk); reset = 1'b1;
    send8(8'h01, 0, lat, wecyc, dout, acked);
    check("t6r_data", dout, 8'h01);
    release8(rel);
    check("t6r_crc_after", crc8, 8'h07);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rx_fifo_crc_framer.md
# rx_fifo_crc_framer

Parametrised receive-side bridge between the parallel word handshake (`tsent`/`trecieve`) and the write port of the downstream FIFO. Each accepted word gets a running CRC, computed `BPC` bits per cycle, and is pushed to the FIFO with `fifo_busy` back-pressure. In frame mode it appends the frame CRC as an extra FIFO word every `FRAME_LEN` words. It adds FIFO-stall timeout detection with sticky error flags.

## Interface
- `DATA_W`, 8, word width; must be a multiple of `BPC`.
- `BPC`, 1, CRC bits consumed per clock.
- `CRC_W`, 8, CRC width; must be ≤ `DATA_W`.
- `CRC_POLY`, 8'h07, generator polynomial, MSB-first, non-reflected, no final XOR.
- `CRC_INIT`, 0, CRC value at reset and at each frame start.
- `FRAME_LEN`, 4, data words per frame; must be ≥ 1.
- `TIMEOUT`, 255, maximum number of `fifo_busy` cycles tolerated per push.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, the FSM and all registers hold their values.
- `append_crc` in 1: frame mode; sampled only in `WAIT_REQ`.
- `rx_data` in `DATA_W`: word from the upstream receiver; bit `DATA_W-1` enters the CRC first.
- `tsent` in 1: upstream word-valid request (four-phase).
- `trecieve` out 1: acknowledge to upstream.
- `fifo_busy` in 1: FIFO cannot accept a write.
- `fifo_we` out 1: one-cycle FIFO write strobe.
- `fifo_data` out `DATA_W`: FIFO write data.
- `crc` out `CRC_W`: CRC of the last completed frame, or the running CRC when `append_crc`=0.
- `idle` out 1: FSM is in `WAIT_REQ`.
- `frame_done` out 1: one-cycle pulse after the CRC word is written.
- `error` out 4: sticky flags. [0] data push timeout, [1] CRC push timeout, [3:2] reserved, read as 0.
- `clr_err` in 1: synchronous clear of `error`; wins over a same-cycle set.

## Operation
- Reset values: `trecieve`=0, `fifo_we`=0, `fifo_data`=0, `crc`=`CRC_INIT`, `idle`=1, `frame_done`=0, `error`=0, word count=0, state=`WAIT_REQ`.
- All outputs are registered.
- `WAIT_REQ`:
  - `idle`=1.
  - On `tsent`=1: latch `rx_data` into the shift register, latch `append_crc`, set `idle`=0, load beat count `DATA_W/BPC-1`, go to `SHIFT`.
- `SHIFT`:
  - Each cycle, fold the top `BPC` bits into the running CRC and shift left by `BPC`.
  - When the beat count reaches 0, go to `PUSH`; otherwise decrement it.
- `PUSH`:
  - If `fifo_busy`=0: set `fifo_data`=latched word and `fifo_we`=1, go to `ACK`.
  - Otherwise increment the timeout counter.
  - When the counter reaches `TIMEOUT`: set `error[0]`, drop the word (no write), go to `ACK`.
- `ACK`: `fifo_we`=0, `trecieve`=1, increment word count, clear the timeout counter, go to `REL`.
- `REL`:
  - Wait for `tsent`=0, then set `trecieve`=0.
  - If frame mode and word count = `FRAME_LEN`, go to `CRC_PUSH`; otherwise go to `WAIT_REQ`.
- `CRC_PUSH`:
  - Same rules as `PUSH`, with `fifo_data`={zero pad, running CRC}.
  - A timeout sets `error[1]` instead of `error[0]`.
- `CRC_DONE`:
  - `fifo_we`=0.
  - `frame_done`=1 for one cycle.
  - `crc` ← running CRC.
  - Running CRC ← `CRC_INIT`, word count ← 0.
  - Go to `WAIT_REQ`.
- Non-frame mode: `crc` tracks the running CRC after every word; the CRC never resets except by `reset`.
- Word count width is clog2(`FRAME_LEN`+1). The count wraps to 0 after `FRAME_LEN` in non-frame mode.
- A dropped (timed-out) word still updates the CRC and the word count.
- `reset` asserted mid-operation returns every register to its reset value immediately. A partially pushed frame is abandoned.
- `enable`=0 during `PUSH` freezes the timeout counter. `fifo_we` holds its current value.
- Illegal state encodings go to `WAIT_REQ`.

## Timing
- `tsent` sampled high at edge E0 (defaults, `BPC`=1):
  - `SHIFT` occupies edges E1–E8.
  - `fifo_we` is high E9–E10.
  - `trecieve` rises at E10.
- General latency from `tsent` to `fifo_we` is `DATA_W/BPC`+1 edges, plus the number of busy cycles.
- `trecieve` falls on the first edge that samples `tsent`=0.
- `tsent` must stay high until `trecieve` is seen; the next request is accepted no earlier than 1 edge after `trecieve` falls.
- The CRC word `fifo_we` follows the last data `trecieve` fall by 1 edge when not busy. `frame_done` coincides with `fifo_we` falling.
- The timeout fires on the `TIMEOUT`-th consecutive busy sample; no write occurs in that cycle.

## Test plan
1. Defaults, `append_crc`=0, one word 8'h01, FIFO free:
   - `fifo_we` is high for exactly 1 cycle, 9 edges after `tsent`, with `fifo_data`=8'h01.
   - `crc`=8'h07.
   - Four-phase handshake completes.
2. `append_crc`=1, `FRAME_LEN`=9, ASCII "123456789":
   - 10 FIFO writes, the last one 8'hF4.
   - `frame_done` pulses once; `crc`=8'hF4.
   - A second identical frame again gives 8'hF4.
3. `BPC`=4, `DATA_W`=16, `CRC_W`=8: results match the `BPC`=1 CRC, and the latency shrinks to 5 edges.
4. `fifo_busy` held high for 3 cycles, then released: the write occurs on the 4th edge, and `error`=0.
5. `TIMEOUT`=4, `fifo_busy` held high:
   - No write occurs; `error[0]`=1 after the 4th busy edge.
   - The word is still acked.
   - `clr_err` returns `error` to 0.
6. `reset` pulsed low during `SHIFT` and during `REL`: all outputs return to reset values asynchronously, and the next word is processed normally from `CRC_INIT`.
